uart_digit_collector: RTL



---
 rtl/uart_digit_collector_pkg.sv | 32 +++
 rtl/uart_digit_collector_if.sv | 43 ++++
 rtl/uart_digit_collector_echo_sequencer.sv | 80 ++++++++
 rtl/uart_digit_collector.sv | 131 +++++++++++++
 4 files changed

// File: rtl/uart_digit_collector_pkg.sv
// uart_digit_collector shared definitions.
// ASCII constants, default width, entry FSM encoding.
package uart_digit_collector_pkg;

  localparam int DIGITS_DEF = 12;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    FULL
  } entry_state_t;

  typedef enum logic {
    ECHO_IDLE,
    ECHO_SEND
  } echo_state_t;

  function automatic logic is_digit(
    input logic [7:0] b
  );
    return (b >= CH_ZERO) && (b <= CH_NINE);
  endfunction

endpackage

// File: rtl/uart_digit_collector_if.sv
// uart_digit_collector bus: rx strobe in, committed
// string out, optional echo handshake.
interface uart_digit_collector_if
  import uart_digit_collector_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
);

  logic [7:0]                    rx_data;
  logic                          rx_valid;
  logic [8*DIGITS-1:0]           buffer;
  logic                          buf_valid;
  logic [$clog2(DIGITS+1)-1:0]   digit_count;
  logic                          overflow;
  logic [7:0]                    tx_data;
  logic                          tx_valid;
  logic                          tx_ready;

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  tx_ready,
    output buffer,
    output buf_valid,
    output digit_count,
    output overflow,
    output tx_data,
    output tx_valid
  );

  modport master (
    output rx_data,
    output rx_valid,
    output tx_ready,
    input  buffer,
    input  buf_valid,
    input  digit_count,
    input  overflow,
    input  tx_data,
    input  tx_valid
  );

endinterface

// File: rtl/uart_digit_collector_echo_sequencer.sv
// echo_sequencer: plays out up to 3 echo bytes over
// a valid/ready handshake. Loads are ignored while busy.
module echo_sequencer
  import uart_digit_collector_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [1:0]  len,
  input  logic [23:0] seq_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  echo_state_t state, state_n;
  logic [1:0]  idx, idx_n;
  logic [1:0]  len_q, len_n;
  logic [23:0] seq, seq_n;
  logic [7:0]  cur;

  // sequencer state and loaded byte sequence
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ECHO_IDLE;
      idx   <= 2'd0;
      len_q <= 2'd0;
      seq   <= 24'h0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      len_q <= len_n;
      seq   <= seq_n;
    end
  end

  // load when idle, advance on each accepted byte
  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len_q;
    seq_n   = seq;
    unique case (state)
      ECHO_IDLE: begin
        if (load) begin
          seq_n   = seq_in;
          len_n   = len;
          idx_n   = 2'd0;
          state_n = ECHO_SEND;
        end
      end
      ECHO_SEND: begin
        if (tx_ready) begin
          if (idx == len_q - 2'd1) begin
            state_n = ECHO_IDLE;
            idx_n   = 2'd0;
          end else begin
            idx_n = idx + 2'd1;
          end
        end
      end
      default: state_n = ECHO_IDLE;
    endcase
  end

  // current byte, first byte in the MSB of seq
  always_comb begin
    cur = 8'h00;
    unique case (idx)
      2'd0:    cur = seq[23:16];
      2'd1:    cur = seq[15:8];
      2'd2:    cur = seq[7:0];
      default: cur = 8'h00;
    endcase
  end

  assign tx_valid = (state == ECHO_SEND);
  assign tx_data  = tx_valid ? cur : 8'h00;

endmodule

// File: rtl/uart_digit_collector.sv
// uart_digit_collector: assembles ASCII digits into a
// '0'-padded string. Echo built with UART_DIGIT_COLLECTOR_ECHO_EN.
module uart_digit_collector
  import uart_digit_collector_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
)(
  input  logic                   clk,
  input  logic                   reset,
  uart_digit_collector_if.slave  bus
);

  localparam int W  = 8 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [W-1:0] ZFILL = {DIGITS{CH_ZERO}};

  entry_state_t  state, state_n;
  logic [W-1:0]  work, work_n;
  logic [W-1:0]  buffer_q, buffer_n;
  logic [CW-1:0] count, count_n;
  logic          ovf_q, ovf_n;
  logic          bv_q, bv_n;

  logic          echo_go;
  logic [1:0]    echo_len;
  logic [23:0]   echo_seq;

  // entry state, working string and committed buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      work     <= ZFILL;
      buffer_q <= ZFILL;
      count    <= '0;
      ovf_q    <= 1'b0;
      bv_q     <= 1'b0;
    end else begin
      state    <= state_n;
      work     <= work_n;
      buffer_q <= buffer_n;
      count    <= count_n;
      ovf_q    <= ovf_n;
      bv_q     <= bv_n;
    end
  end

  // byte decode: edit, commit or clear the entry
  always_comb begin
    state_n  = state;
    work_n   = work;
    buffer_n = buffer_q;
    count_n  = count;
    ovf_n    = ovf_q;
    bv_n     = 1'b0;
    echo_go  = 1'b0;
    echo_len = 2'd0;
    echo_seq = 24'h0;
    if (bus.rx_valid) begin
      unique case (1'b1)
        is_digit(bus.rx_data): begin
          if (state != FULL) begin
            work_n   = {work[W-9:0], bus.rx_data};
            count_n  = count + 1'b1;
            state_n  = (count_n == CW'(DIGITS)) ? FULL : ENTRY;
            echo_go  = 1'b1;
            echo_len = 2'd1;
            echo_seq = {bus.rx_data, 16'h0};
          end else begin
            ovf_n = 1'b1;
          end
        end
        (bus.rx_data == CH_BS): begin
          if (state != EMPTY) begin
            work_n   = {CH_ZERO, work[W-1:8]};
            count_n  = count - 1'b1;
            state_n  = (count_n == '0) ? EMPTY : ENTRY;
            echo_go  = 1'b1;
            echo_len = 2'd3;
            echo_seq = {CH_BS, CH_SPACE, CH_BS};
          end
        end
        (bus.rx_data == CH_CR): begin
          buffer_n = work;
          bv_n     = 1'b1;
          work_n   = ZFILL;
          count_n  = '0;
          ovf_n    = 1'b0;
          state_n  = EMPTY;
          echo_go  = 1'b1;
          echo_len = 2'd2;
          echo_seq = {CH_CR, CH_LF, 8'h00};
        end
        (bus.rx_data == CH_ESC): begin
          work_n   = ZFILL;
          count_n  = '0;
          ovf_n    = 1'b0;
          state_n  = EMPTY;
          echo_go  = 1'b1;
          echo_len = 2'd2;
          echo_seq = {CH_CR, CH_LF, 8'h00};
        end
        default: ;
      endcase
    end
  end

  assign bus.buffer      = buffer_q;
  assign bus.buf_valid   = bv_q;
  assign bus.digit_count = count;
  assign bus.overflow    = ovf_q;

`ifdef UART_DIGIT_COLLECTOR_ECHO_EN
  echo_sequencer u_echo (
    .clk      (clk),
    .reset    (reset),
    .load     (echo_go),
    .len      (echo_len),
    .seq_in   (echo_seq),
    .tx_data  (bus.tx_data),
    .tx_valid (bus.tx_valid),
    .tx_ready (bus.tx_ready)
  );
`else
  logic unused_echo;
  assign unused_echo  = &{1'b0, bus.tx_ready, echo_go,
                          echo_len, echo_seq};
  assign bus.tx_valid = 1'b0;
  assign bus.tx_data  = 8'h00;
`endif

endmodule
